// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter
// N-master x M-bank crossbar in front of single-port bank SRAMs. Requests are
// steered by low-order address interleaving. Each bank has its own round-robin
// arbiter and a registered command port. Read data returns to the issuing
// master after a fixed latency.
//
// Handshake: a master holds m_req and its payload stable until m_gnt.
// A transfer happens in any cycle where m_req & m_gnt are both high.
// m_gnt is combinational. m_rvalid is a one-cycle strobe with no back-pressure.
module banked_mem_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LAT      = 1,
    // Derived widths; do not override.
    parameter int BSEL        = $clog2(NUM_BANKS),
    parameter int BAW         = ADDR_WIDTH - BSEL,
    parameter int BE          = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS*BE-1:0]         m_be,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_BANKS-1:0]              b_en,
    output logic [NUM_BANKS-1:0]              b_we,
    output logic [NUM_BANKS*BAW-1:0]          b_addr,
    output logic [NUM_BANKS*BE-1:0]           b_be,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]   b_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]   b_rdata
);

    localparam int MIDW = $clog2(NUM_MASTERS);

    // Per-master views of the packed request buses
    logic [BSEL-1:0]       tgt     [NUM_MASTERS];
    logic [BAW-1:0]        m_baddr [NUM_MASTERS];
    logic [BE-1:0]         m_be_a  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] m_wd_a  [NUM_MASTERS];

    // Round-robin pointers and per-bank grant decision
    logic [MIDW-1:0]      ptr_q    [NUM_BANKS];
    logic [MIDW-1:0]      ptr_d    [NUM_BANKS];
    logic [NUM_BANKS-1:0] bgnt_vld;
    logic [MIDW-1:0]      bgnt_id  [NUM_BANKS];
    logic [MIDW:0]        cand;

    // Bank command registers
    logic [NUM_BANKS-1:0]            b_en_q, b_en_d;
    logic [NUM_BANKS-1:0]            b_we_q, b_we_d;
    logic [NUM_BANKS*BAW-1:0]        b_addr_q, b_addr_d;
    logic [NUM_BANKS*BE-1:0]         b_be_q, b_be_d;
    logic [NUM_BANKS*DATA_WIDTH-1:0] b_wdata_q, b_wdata_d;
    logic [MIDW-1:0]                 cmd_id_q [NUM_BANKS];
    logic [MIDW-1:0]                 cmd_id_d [NUM_BANKS];

    // Read-return tracking: {valid, master id} per bank, RD_LAT stages deep
    logic [RD_LAT-1:0] rv_vld_q [NUM_BANKS];
    logic [RD_LAT-1:0] rv_vld_d [NUM_BANKS];
    logic [MIDW-1:0]   rv_id_q  [NUM_BANKS][RD_LAT];
    logic [MIDW-1:0]   rv_id_d  [NUM_BANKS][RD_LAT];

    // Master-side read return registers
    logic [NUM_MASTERS-1:0]            m_rvalid_q, m_rvalid_d;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic [MIDW-1:0]                   rid;

    // Split packed master buses into per-master fields; bank = low address bits
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            tgt[i]     = m_addr[i*ADDR_WIDTH +: BSEL];
            m_baddr[i] = m_addr[i*ADDR_WIDTH+BSEL +: BAW];
            m_be_a[i]  = m_be[i*BE +: BE];
            m_wd_a[i]  = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Per-bank search: first requester targeting this bank, starting at ptr, ascending with wrap
    always_comb begin
        cand = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            bgnt_vld[j] = 1'b0;
            bgnt_id[j]  = '0;
            for (int o = 0; o < NUM_MASTERS; o++) begin
                cand = {1'b0, ptr_q[j]} + (MIDW+1)'(o);
                if (cand >= (MIDW+1)'(NUM_MASTERS)) begin
                    cand = cand - (MIDW+1)'(NUM_MASTERS);
                end
                if (!bgnt_vld[j] && m_req[cand[MIDW-1:0]] &&
                    (tgt[cand[MIDW-1:0]] == BSEL'(j))) begin
                    bgnt_vld[j] = 1'b1;
                    bgnt_id[j]  = cand[MIDW-1:0];
                end
            end
        end
    end

    // Fold bank grants onto the master grant vector; held low during reset
    always_comb begin
        m_gnt = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            if (bgnt_vld[j]) begin
                m_gnt[bgnt_id[j]] = 1'b1;
            end
        end
        if (!rst_n) begin
            m_gnt = '0;
        end
    end

    // Pointer advances past the granted master, holds otherwise
    always_comb begin
        for (int j = 0; j < NUM_BANKS; j++) begin
            ptr_d[j] = ptr_q[j];
            if (bgnt_vld[j]) begin
                ptr_d[j] = (bgnt_id[j] == MIDW'(NUM_MASTERS-1)) ? '0 : bgnt_id[j] + MIDW'(1);
            end
        end
    end

    // Round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_BANKS; j++) begin
                ptr_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_BANKS; j++) begin
                ptr_q[j] <= ptr_d[j];
            end
        end
    end

    // Next bank command: strobe only on a grant, payload fields hold when idle
    always_comb begin
        b_en_d    = '0;
        b_we_d    = '0;
        b_addr_d  = b_addr_q;
        b_be_d    = b_be_q;
        b_wdata_d = b_wdata_q;
        for (int j = 0; j < NUM_BANKS; j++) begin
            cmd_id_d[j] = cmd_id_q[j];
            if (bgnt_vld[j]) begin
                b_en_d[j]                           = 1'b1;
                b_we_d[j]                           = m_wr[bgnt_id[j]];
                b_addr_d[j*BAW +: BAW]              = m_baddr[bgnt_id[j]];
                b_be_d[j*BE +: BE]                  = m_be_a[bgnt_id[j]];
                b_wdata_d[j*DATA_WIDTH +: DATA_WIDTH] = m_wd_a[bgnt_id[j]];
                cmd_id_d[j]                         = bgnt_id[j];
            end
        end
    end

    // Bank command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_en_q    <= '0;
            b_we_q    <= '0;
            b_addr_q  <= '0;
            b_be_q    <= '0;
            b_wdata_q <= '0;
            for (int j = 0; j < NUM_BANKS; j++) begin
                cmd_id_q[j] <= '0;
            end
        end else begin
            b_en_q    <= b_en_d;
            b_we_q    <= b_we_d;
            b_addr_q  <= b_addr_d;
            b_be_q    <= b_be_d;
            b_wdata_q <= b_wdata_d;
            for (int j = 0; j < NUM_BANKS; j++) begin
                cmd_id_q[j] <= cmd_id_d[j];
            end
        end
    end

    assign b_en    = b_en_q;
    assign b_we    = b_we_q;
    assign b_addr  = b_addr_q;
    assign b_be    = b_be_q;
    assign b_wdata = b_wdata_q;

    // Shift read tags alongside the bank so the last stage lines up with b_rdata
    always_comb begin
        for (int j = 0; j < NUM_BANKS; j++) begin
            rv_vld_d[j]    = '0;
            rv_vld_d[j][0] = b_en_q[j] & ~b_we_q[j];
            rv_id_d[j][0]  = cmd_id_q[j];
            for (int s = 1; s < RD_LAT; s++) begin
                rv_vld_d[j][s] = rv_vld_q[j][s-1];
                rv_id_d[j][s]  = rv_id_q[j][s-1];
            end
        end
    end

    // Read-tag pipeline; reset discards reads in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_BANKS; j++) begin
                rv_vld_q[j] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    rv_id_q[j][s] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < NUM_BANKS; j++) begin
                rv_vld_q[j] <= rv_vld_d[j];
                for (int s = 0; s < RD_LAT; s++) begin
                    rv_id_q[j][s] <= rv_id_d[j][s];
                end
            end
        end
    end

    // Route emerging bank data to the tagged master; data holds when no return
    always_comb begin
        m_rvalid_d = '0;
        m_rdata_d  = m_rdata_q;
        rid        = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            if (rv_vld_q[j][RD_LAT-1]) begin
                rid                                              = rv_id_q[j][RD_LAT-1];
                m_rvalid_d[rid]                                  = 1'b1;
                m_rdata_d[int'(rid)*DATA_WIDTH +: DATA_WIDTH]    = b_rdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Master read return registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid_q <= '0;
            m_rdata_q  <= '0;
        end else begin
            m_rvalid_q <= m_rvalid_d;
            m_rdata_q  <= m_rdata_d;
        end
    end

    assign m_rvalid = m_rvalid_q;
    assign m_rdata  = m_rdata_q;

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Testbench for banked_mem_arbiter: directed scenarios plus random traffic,
// with bank SRAM models on the bank side and a reference arbiter/memory model
// feeding a read-return scoreboard.
module tb_banked_mem_arbiter;

    localparam int NM     = 4;
    localparam int NB     = 4;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int BSEL   = 2;
    localparam int BAW    = AW - BSEL;
    localparam int BE     = DW / 8;

    typedef struct packed {
        logic [7:0]    m;
        logic [31:0]   due;
        logic [DW-1:0] d;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    logic [NM-1:0]    m_req, m_wr, m_gnt, m_rvalid;
    logic [NM*AW-1:0] m_addr;
    logic [NM*BE-1:0] m_be;
    logic [NM*DW-1:0] m_wdata, m_rdata;
    logic [NB-1:0]    b_en, b_we;
    logic [NB*BAW-1:0] b_addr;
    logic [NB*BE-1:0] b_be;
    logic [NB*DW-1:0] b_wdata, b_rdata;

    banked_mem_arbiter #(
        .NUM_MASTERS(NM), .NUM_BANKS(NB), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_addr(m_addr), .m_wr(m_wr), .m_be(m_be), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(b_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Initial memory contents, shared by the bank SRAMs and the reference memory
    function automatic logic [DW-1:0] init_word(input int a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- bank SRAM models ----------------
    logic [DW-1:0] sram [int];
    logic [DW-1:0] rd_pipe [NB][RD_LAT];
    int            sa;
    logic [DW-1:0] sw;

    always @(posedge clk) begin
        for (int j = 0; j < NB; j++) begin
            for (int s = 1; s < RD_LAT; s++) rd_pipe[j][s] <= rd_pipe[j][s-1];
            rd_pipe[j][0] <= $urandom();
            if (b_en[j]) begin
                sa = int'(b_addr[j*BAW +: BAW]) * NB + j;
                sw = sram.exists(sa) ? sram[sa] : init_word(sa);
                if (b_we[j]) begin
                    for (int b = 0; b < BE; b++)
                        if (b_be[j*BE+b]) sw[b*8 +: 8] = b_wdata[j*DW+b*8 +: 8];
                    sram[sa] = sw;
                end else begin
                    rd_pipe[j][0] <= sw;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NB; j++) b_rdata[j*DW +: DW] = rd_pipe[j][RD_LAT-1];
    end

    // ---------------- reference model + scoreboard ----------------
    int            ptr [NB];
    logic [NM-1:0] model_gnt;
    logic [NB-1:0] eb_en, eb_we;
    logic [BAW-1:0] eb_addr [NB];
    logic [BE-1:0]  eb_be   [NB];
    logic [DW-1:0]  eb_wd   [NB];
    logic [DW-1:0]  last_rd [NM];
    logic [DW-1:0]  ref_mem [int];
    exp_t           exp_q[$];
    exp_t           e;
    int             k, win, fa, idx;
    logic [DW-1:0]  mw;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("gnt_in_reset", m_gnt, 0);
            check("ben_in_reset", b_en, 0);
            check("rvalid_in_reset", m_rvalid, 0);
            check("baddr_in_reset", b_addr, 0);
            check("rdata_in_reset", m_rdata, 0);
            for (int j = 0; j < NB; j++) begin
                ptr[j] = 0; eb_addr[j] = '0; eb_be[j] = '0; eb_wd[j] = '0;
            end
            for (int i = 0; i < NM; i++) last_rd[i] = '0;
            eb_en = '0; eb_we = '0; model_gnt = '0;
            exp_q.delete();
        end else begin
            // bank command from last cycle's grants
            for (int j = 0; j < NB; j++) begin
                check("b_en", b_en[j], eb_en[j]);
                check("b_addr", b_addr[j*BAW +: BAW], eb_addr[j]);
                check("b_be", b_be[j*BE +: BE], eb_be[j]);
                check("b_wdata", b_wdata[j*DW +: DW], eb_wd[j]);
                if (eb_en[j]) check("b_we", b_we[j], eb_we[j]);
            end
            // read returns
            for (int i = 0; i < NM; i++) begin
                if (m_rvalid[i]) begin
                    idx = -1;
                    for (int q = 0; q < exp_q.size(); q++)
                        if (idx < 0 && exp_q[q].m == 8'(i)) idx = q;
                    if (idx < 0) begin
                        total++; bad++;
                        $display("FAIL rvalid_unexpected: master %0d rvalid=1 with no read outstanding (cycle %0d)", i, cyc);
                    end else begin
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        check("rd_latency", 64'(cyc), 64'(e.due));
                        last_rd[i] = e.d;
                    end
                end
                check("m_rdata", m_rdata[i*DW +: DW], last_rd[i]);
            end
            for (int q = exp_q.size() - 1; q >= 0; q--) begin
                if (int'(exp_q[q].due) < cyc) begin
                    total++; bad++;
                    $display("FAIL rvalid_missing: master %0d expected return at cycle %0d, none by cycle %0d",
                             exp_q[q].m, exp_q[q].due, cyc);
                    exp_q.delete(q);
                end
            end
            // arbitration: first requester of bank j scanning from ptr[j] upward with wrap
            model_gnt = '0;
            for (int j = 0; j < NB; j++) begin
                win = -1;
                for (int o = 0; o < NM; o++) begin
                    k = (ptr[j] + o) % NM;
                    if (win < 0 && m_req[k] && int'(m_addr[k*AW +: BSEL]) == j) win = k;
                end
                eb_en[j] = (win >= 0);
                if (win >= 0) begin
                    model_gnt[win] = 1'b1;
                    ptr[j]     = (win + 1) % NM;
                    fa         = int'(m_addr[win*AW +: AW]);
                    eb_addr[j] = m_addr[win*AW+BSEL +: BAW];
                    eb_we[j]   = m_wr[win];
                    eb_be[j]   = m_be[win*BE +: BE];
                    eb_wd[j]   = m_wdata[win*DW +: DW];
                    mw = ref_mem.exists(fa) ? ref_mem[fa] : init_word(fa);
                    if (m_wr[win]) begin
                        for (int b = 0; b < BE; b++)
                            if (m_be[win*BE+b]) mw[b*8 +: 8] = m_wdata[win*DW+b*8 +: 8];
                        ref_mem[fa] = mw;
                    end else begin
                        e.m   = 8'(win);
                        e.due = 32'(cyc + 2 + RD_LAT);
                        e.d   = mw;
                        exp_q.push_back(e);
                    end
                end
            end
            check("m_gnt", m_gnt, model_gnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance one cycle and retire the requests that transferred
    task automatic step();
        tick();
        for (int i = 0; i < NM; i++) if (model_gnt[i]) m_req[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                           input logic [BE-1:0] be, input logic [DW-1:0] wd);
        m_req[i]             = 1'b1;
        m_wr[i]              = wr;
        m_addr[i*AW +: AW]   = addr;
        m_be[i*BE +: BE]     = be;
        m_wdata[i*DW +: DW]  = wd;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_req != '0 && n < 200) begin
            step();
            n++;
        end
        if (m_req != '0) begin
            total++; bad++;
            $display("FAIL drain_timeout: m_req=%0h still pending after 200 cycles", m_req);
            m_req = '0;
        end
        repeat (RD_LAT + 4) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        m_req = '0; m_wr = '0; m_addr = '0; m_be = '0; m_wdata = '0;

        // reset with every master requesting bank 2; master 0 must win first
        for (int i = 0; i < NM; i++) set_req(i, 1'b0, 16'((i << 2) | 2), 4'hF, $urandom());
        repeat (3) tick();
        rst_n = 1'b1;
        drain();

        // parallel: one read per bank in the same cycle
        for (int i = 0; i < NM; i++) set_req(i, 1'b0, 16'(16'h0010 + i), 4'($urandom()), $urandom());
        drain();

        // contention: all masters keep hitting bank 2
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NM; i++)
                if (!m_req[i]) set_req(i, 1'b0, 16'(($urandom_range(0, 63) << 2) | 2), 4'hF, $urandom());
            step();
        end
        drain();

        // partial write then read back by another master
        set_req(1, 1'b1, 16'h0005, 4'b0011, 32'hDEAD_BEEF);
        drain();
        set_req(3, 1'b0, 16'h0005, 4'h0, $urandom());
        drain();

        // back-to-back reads from one master across banks 0,1,2
        for (int b = 0; b < 3; b++) begin
            set_req(2, 1'b0, 16'(16'h0040 + b), 4'hF, $urandom());
            step();
        end
        drain();

        // random traffic over a small address window to provoke read-after-write
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NM; i++)
                if (!m_req[i] && $urandom_range(0, 9) < 6)
                    set_req(i, ($urandom_range(0, 9) < 4), 16'($urandom_range(0, 31)),
                            4'($urandom()), $urandom());
            step();
        end
        drain();

        // reset one cycle after a read grant; that read must never return
        set_req(0, 1'b0, 16'h0008, 4'hF, $urandom());
        step();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (RD_LAT + 8) step();

        check("queue_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
